// File: rtl/result_bus_arbiter.sv
// result_bus_arbiter: round-robin arbiter that shares a single registered
// result/update broadcast slot among UNITS execution units.
module result_bus_arbiter #(
  parameter int unsigned UNITS         = 4,
  parameter int unsigned OPERAND_WIDTH = 32,
  parameter int unsigned RS_ID_WIDTH   = 5
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [UNITS-1:0]                        unit_valid,
  output logic [UNITS-1:0]                        unit_ready,
  input  logic [UNITS-1:0][RS_ID_WIDTH-1:0]       unit_rs_id,
  input  logic [UNITS-1:0][OPERAND_WIDTH-1:0]     unit_value,
  output logic                                    result_valid,
  input  logic                                    result_ready,
  output logic [RS_ID_WIDTH-1:0]                  result_rs_id,
  output logic [OPERAND_WIDTH-1:0]                result_value,
  output logic [$clog2(UNITS)-1:0]                grant_idx
);

  localparam int unsigned IDX_W = $clog2(UNITS);
  localparam int unsigned SUM_W = IDX_W + 1;

  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] next_ptr;
  logic [IDX_W-1:0] cand;
  logic [SUM_W-1:0] cand_sum;
  logic             found;
  logic             load_en;

  // The slot can take a new result when empty or being drained this cycle.
  assign load_en = ~result_valid | result_ready;

  // Pointer after a grant; wraps explicitly so non-power-of-2 UNITS stay in range.
  assign next_ptr = (win == IDX_W'(UNITS - 1)) ? '0 : win + IDX_W'(1);

  // Round-robin scan starting at rr_ptr, modulo UNITS; first valid unit wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned k = 0; k < UNITS; k++) begin
      cand_sum = {1'b0, rr_ptr} + SUM_W'(k);
      if (cand_sum >= SUM_W'(UNITS)) begin
        cand_sum = cand_sum - SUM_W'(UNITS);
      end
      cand = cand_sum[IDX_W-1:0];
      if (!found && unit_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  // Accept handshake back to the winning unit; silenced while in reset.
  always_comb begin
    unit_ready = '0;
    if (rst && load_en && found) begin
      unit_ready[win] = 1'b1;
    end
  end

  // Broadcast slot and round-robin pointer; pointer moves only on a transfer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      result_valid <= 1'b0;
      result_rs_id <= '0;
      result_value <= '0;
      grant_idx    <= '0;
      rr_ptr       <= '0;
    end else if (load_en) begin
      if (found) begin
        result_valid <= 1'b1;
        result_rs_id <= unit_rs_id[win];
        result_value <= unit_value[win];
        grant_idx    <= win;
        rr_ptr       <= next_ptr;
      end else begin
        result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_result_bus_arbiter.sv
// Testbench for result_bus_arbiter: vector table, hand corner sequences and
// randomized traffic on a 4-unit and a 3-unit instance against a reference model.
module tb_result_bus_arbiter;

  localparam int unsigned OW = 32;
  localparam int unsigned RW = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 4-unit instance
  logic                 rst_a;
  logic [3:0]           uv_a;
  logic [3:0]           ready_a;
  logic [3:0][RW-1:0]   id_a;
  logic [3:0][OW-1:0]   val_a;
  logic                 rv_a;
  logic                 rr_a;
  logic [RW-1:0]        rid_a;
  logic [OW-1:0]        rval_a;
  logic [1:0]           g_a;

  // 3-unit instance
  logic                 rst_b;
  logic [2:0]           uv_b;
  logic [2:0]           ready_b;
  logic [2:0][RW-1:0]   id_b;
  logic [2:0][OW-1:0]   val_b;
  logic                 rv_b;
  logic                 rr_b;
  logic [RW-1:0]        rid_b;
  logic [OW-1:0]        rval_b;
  logic [1:0]           g_b;

  result_bus_arbiter #(.UNITS(4), .OPERAND_WIDTH(OW), .RS_ID_WIDTH(RW)) dut_a (
    .clk(clk), .rst(rst_a), .unit_valid(uv_a), .unit_ready(ready_a),
    .unit_rs_id(id_a), .unit_value(val_a), .result_valid(rv_a),
    .result_ready(rr_a), .result_rs_id(rid_a), .result_value(rval_a),
    .grant_idx(g_a)
  );

  result_bus_arbiter #(.UNITS(3), .OPERAND_WIDTH(OW), .RS_ID_WIDTH(RW)) dut_b (
    .clk(clk), .rst(rst_b), .unit_valid(uv_b), .unit_ready(ready_b),
    .unit_rs_id(id_b), .unit_value(val_b), .result_valid(rv_b),
    .result_ready(rr_b), .result_rs_id(rid_b), .result_value(rval_b),
    .grant_idx(g_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model state, index 0 = 4-unit, 1 = 3-unit.
  logic          m_rv  [2];
  logic [RW-1:0] m_id  [2];
  logic [OW-1:0] m_val [2];
  int            m_g   [2];
  int            m_ptr [2];

  // First requesting unit at or after ptr, counting modulo n; -1 if none.
  function automatic int pick(input logic [3:0] v, input int ptr, input int n);
    for (int k = 0; k < n; k++) begin
      int i;
      i = (ptr + k) % n;
      if (v[2'(i)]) return i;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_ready(input int d, input logic r, input logic [3:0] v,
                                           input logic rr, input int n);
    int w;
    w = pick(v, m_ptr[d], n);
    if (r && (!m_rv[d] || rr) && w >= 0) return 4'(1) << w;
    return 4'd0;
  endfunction

  task automatic model_step(input int d, input logic r, input logic [3:0] v, input logic rr,
                            input logic [3:0][RW-1:0] ids, input logic [3:0][OW-1:0] vals,
                            input int n);
    int w;
    if (!r) begin
      m_rv[d] = 1'b0; m_id[d] = '0; m_val[d] = '0; m_g[d] = 0; m_ptr[d] = 0;
    end else if (!m_rv[d] || rr) begin
      w = pick(v, m_ptr[d], n);
      if (w >= 0) begin
        m_rv[d]  = 1'b1;
        m_id[d]  = ids[2'(w)];
        m_val[d] = vals[2'(w)];
        m_g[d]   = w;
        m_ptr[d] = (w + 1) % n;
      end else begin
        m_rv[d] = 1'b0;
      end
    end
  endtask

  task automatic drive_a(input logic r, input logic [3:0] v, input logic rr);
    @(negedge clk);
    rst_a = r; uv_a = v; rr_a = rr;
    #1;
  endtask

  task automatic drive_b(input logic r, input logic [2:0] v, input logic rr);
    @(negedge clk);
    rst_b = r; uv_b = v; rr_b = rr;
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] uv;
    logic       rr;
    logic [3:0] ready;
    logic       rv;
    logic [1:0] g;
  } vec_t;

  vec_t tbl [20];

  initial begin
    // rst, unit_valid, result_ready | unit_ready, result_valid, grant_idx (pre-edge)
    tbl[0]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd0};
    tbl[1]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[2]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[3]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[4]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b1, 2'd3};
    tbl[5]  = '{1'b1, 4'b1111, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[6]  = '{1'b1, 4'b1111, 1'b1, 4'b0100, 1'b1, 2'd1};
    tbl[7]  = '{1'b1, 4'b1111, 1'b1, 4'b1000, 1'b1, 2'd2};
    tbl[8]  = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[9]  = '{1'b1, 4'b1111, 1'b1, 4'b0001, 1'b0, 2'd3};
    tbl[10] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[11] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[12] = '{1'b1, 4'b1010, 1'b0, 4'b0000, 1'b1, 2'd0};
    tbl[13] = '{1'b1, 4'b1010, 1'b1, 4'b0010, 1'b1, 2'd0};
    tbl[14] = '{1'b1, 4'b1010, 1'b1, 4'b1000, 1'b1, 2'd1};
    tbl[15] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3};
    tbl[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd3};
    tbl[17] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3};
    tbl[18] = '{1'b1, 4'b1111, 1'b0, 4'b0001, 1'b0, 2'd3};
    tbl[19] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};

    rst_a = 1'b0; uv_a = '0; rr_a = 1'b0;
    rst_b = 1'b0; uv_b = '0; rr_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      id_a[i]  = RW'(10 + i);
      val_a[i] = 32'hA000_0000 + OW'(i);
    end
    for (int i = 0; i < 3; i++) begin
      id_b[i]  = RW'(20 + i);
      val_b[i] = 32'hB000_0000 + OW'(i);
    end

    // Reset held two cycles with every unit requesting.
    drive_a(1'b0, 4'b1111, 1'b1);
    chk("rst_ready0", 64'(ready_a), 64'd0);
    drive_a(1'b0, 4'b1111, 1'b1);
    chk("rst_ready1", 64'(ready_a), 64'd0);
    chk("rst_valid",  64'(rv_a),    64'd0);
    chk("rst_grant",  64'(g_a),     64'd0);
    chk("rst_rs_id",  64'(rid_a),   64'd0);
    chk("rst_value",  64'(rval_a),  64'd0);

    // Vector table: round robin, idle, backpressure, drain/refill.
    for (int i = 0; i < 20; i++) begin
      drive_a(tbl[i].rst, tbl[i].uv, tbl[i].rr);
      chk($sformatf("tbl%0d_ready", i), 64'(ready_a), 64'(tbl[i].ready));
      chk($sformatf("tbl%0d_valid", i), 64'(rv_a),    64'(tbl[i].rv));
      chk($sformatf("tbl%0d_grant", i), 64'(g_a),     64'(tbl[i].g));
      if (tbl[i].rv) begin
        chk($sformatf("tbl%0d_rs_id", i), 64'(rid_a),  64'(10 + int'(tbl[i].g)));
        chk($sformatf("tbl%0d_value", i), 64'(rval_a), 64'(32'hA000_0000 + OW'(tbl[i].g)));
      end
    end

    // Single requester carrying a distinctive payload.
    id_a[2]  = 5'd9;
    val_a[2] = 32'hDEAD_BEEF;
    drive_a(1'b1, 4'b0100, 1'b1);
    chk("single_ready", 64'(ready_a), 64'b0100);
    drive_a(1'b1, 4'b0000, 1'b0);
    chk("single_valid", 64'(rv_a),   64'd1);
    chk("single_rs_id", 64'(rid_a),  64'd9);
    chk("single_value", 64'(rval_a), 64'hDEAD_BEEF);
    chk("single_grant", 64'(g_a),    64'd2);
    id_a[2]  = 5'd12;
    val_a[2] = 32'hA000_0002;

    // Reset while the slot is stalled full discards it.
    drive_a(1'b0, 4'b1111, 1'b0);
    chk("rstmid_ready0", 64'(ready_a), 64'd0);
    drive_a(1'b0, 4'b1111, 1'b0);
    chk("rstmid_ready1", 64'(ready_a), 64'd0);
    chk("rstmid_valid",  64'(rv_a),    64'd0);
    drive_a(1'b1, 4'b1111, 1'b1);
    chk("release_ready", 64'(ready_a), 64'b0001);
    chk("release_valid", 64'(rv_a),    64'd0);
    drive_a(1'b1, 4'b0000, 1'b1);
    chk("release_grant", 64'(g_a),   64'd0);
    chk("release_rs_id", 64'(rid_a), 64'd10);
    chk("release_rvld",  64'(rv_a),  64'd1);

    // Three units: after unit 2 wins, pointer wraps to unit 0.
    drive_b(1'b0, 3'b111, 1'b1);
    drive_b(1'b0, 3'b111, 1'b1);
    chk("wrap_rst_ready", 64'(ready_b), 64'd0);
    drive_b(1'b1, 3'b100, 1'b1);
    chk("wrap_first_ready", 64'(ready_b), 64'b100);
    drive_b(1'b1, 3'b101, 1'b1);
    chk("wrap_prev_grant", 64'(g_b),     64'd2);
    chk("wrap_ready",      64'(ready_b), 64'b001);
    drive_b(1'b1, 3'b000, 1'b1);
    chk("wrap_grant", 64'(g_b),   64'd0);
    chk("wrap_rs_id", 64'(rid_b), 64'd20);

    // Randomized traffic on both instances against the reference model.
    for (int c = 0; c < 600; c++) begin
      logic [3:0] ea;
      logic [3:0] eb;
      @(negedge clk);
      rst_a = (c == 0) ? 1'b0 : ($urandom_range(31) != 0);
      rst_b = (c == 0) ? 1'b0 : ($urandom_range(31) != 0);
      uv_a  = 4'($urandom);
      uv_b  = 3'($urandom);
      rr_a  = ($urandom_range(3) != 0);
      rr_b  = ($urandom_range(3) != 0);
      for (int i = 0; i < 4; i++) begin
        id_a[i]  = RW'($urandom);
        val_a[i] = $urandom;
      end
      for (int i = 0; i < 3; i++) begin
        id_b[i]  = RW'($urandom);
        val_b[i] = $urandom;
      end
      #1;
      ea = exp_ready(0, rst_a, uv_a, rr_a, 4);
      eb = exp_ready(1, rst_b, {1'b0, uv_b}, rr_b, 3);
      chk("rnd_a_ready", 64'(ready_a), 64'(ea));
      chk("rnd_b_ready", 64'(ready_b), 64'(eb[2:0]));
      if (c != 0) begin
        chk("rnd_a_valid", 64'(rv_a),   64'(m_rv[0]));
        chk("rnd_a_rs_id", 64'(rid_a),  64'(m_id[0]));
        chk("rnd_a_value", 64'(rval_a), 64'(m_val[0]));
        chk("rnd_a_grant", 64'(g_a),    64'(m_g[0]));
        chk("rnd_b_valid", 64'(rv_b),   64'(m_rv[1]));
        chk("rnd_b_rs_id", 64'(rid_b),  64'(m_id[1]));
        chk("rnd_b_value", 64'(rval_b), 64'(m_val[1]));
        chk("rnd_b_grant", 64'(g_b),    64'(m_g[1]));
      end
      model_step(0, rst_a, uv_a, rr_a, id_a, val_a, 4);
      model_step(1, rst_b, {1'b0, uv_b}, rr_b, {RW'(0), id_b}, {OW'(0), val_b}, 3);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
